// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux2_1 block and its select-transition counter.
package mux_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;
  localparam int unsigned CNT_WIDTH_DEFAULT = 8;

  // Largest value representable in a counter of the given width.
  function automatic longint unsigned CNT_MAX_F(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/sel_edge_counter.sv
// Saturating counter of select transitions (s differs from its registered copy s_q),
// with asynchronous assertion and 2-flop synchronised release of reset.
module sel_edge_counter
  import mux_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s,
  output logic [CNT_WIDTH-1:0] sel_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CNT_MAX_F(CNT_WIDTH));

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  logic                 s_q, s_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Falls together with rst_n, rises only after two clean clock edges.
  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    s_d   = s;
    cnt_d = cnt_q;
    if ((s != s_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_cnt = cnt_q;

endmodule

// File: rtl/mux2_1.sv
// WIDTH-bit 2:1 mux with a saturating select-transition counter.
// Define MUX2_1_OUT_REG_EN to register the data output (1-cycle latency, async clear).
module mux2_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH     = MUX_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     i0,
  input  logic [WIDTH-1:0]     i1,
  input  logic                 s,
  output logic [WIDTH-1:0]     out,
  output logic [CNT_WIDTH-1:0] sel_cnt
);

  logic [WIDTH-1:0] mux_d;

  assign mux_d = s ? i1 : i0;

`ifdef MUX2_1_OUT_REG_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= mux_d;
    end
  end

  assign out = out_q;
`else
  assign out = mux_d;
`endif

  sel_edge_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sel_edge_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .sel_cnt (sel_cnt)
  );

endmodule

// File: tb/tb_mux2_1.sv
// Self-checking bench for mux2_1: a 1-bit/8-bit-counter instance and an 8-bit/2-bit-counter
// instance share clk, rst_n and s; results are compared with a behavioural model.
module tb_mux2_1;

  localparam int CNT1_MAX = 255;
  localparam int CNT8_MAX = 3;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic       a0, a1, out1;
  logic [7:0] b0, b1, out8;
  logic [7:0] cnt1;
  logic [1:0] cnt8;

  int n_cmp;
  int n_fail;

  // Behavioural model state
  int         cnt1_m, cnt8_m;
  bit         prev_s_m;
  int         rel_edges_m;
  logic       out1_m;
  logic [7:0] out8_m;

  mux2_1 #(.WIDTH(1), .CNT_WIDTH(8)) u_w1 (
    .clk(clk), .rst_n(rst_n), .i0(a0), .i1(a1), .s(s), .out(out1), .sel_cnt(cnt1)
  );

  mux2_1 #(.WIDTH(8), .CNT_WIDTH(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .i0(b0), .i1(b1), .s(s), .out(out8), .sel_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_async_reset();
    cnt1_m      = 0;
    cnt8_m      = 0;
    prev_s_m    = 1'b0;
    rel_edges_m = 0;
    out1_m      = 1'b0;
    out8_m      = 8'h00;
  endtask

  // One rising edge: counting resumes on the third edge after reset release.
  task automatic model_edge();
    if (!rst_n) begin
      model_async_reset();
    end else begin
      out1_m = s ? a1 : a0;
      out8_m = s ? b1 : b0;
      if (rel_edges_m < 2) begin
        rel_edges_m++;
      end else begin
        if (s != prev_s_m) begin
          if (cnt1_m < CNT1_MAX) cnt1_m++;
          if (cnt8_m < CNT8_MAX) cnt8_m++;
        end
        prev_s_m = s;
      end
    end
  endtask

  function automatic logic exp_out1();
`ifdef MUX2_1_OUT_REG_EN
    return out1_m;
`else
    return s ? a1 : a0;
`endif
  endfunction

  function automatic logic [7:0] exp_out8();
`ifdef MUX2_1_OUT_REG_EN
    return out8_m;
`else
    return s ? b1 : b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_cnt1"}, 32'(cnt1), 32'(cnt1_m));
    check({tag, "_cnt8"}, 32'(cnt8), 32'(cnt8_m));
    check({tag, "_out1"}, 32'(out1), 32'(exp_out1()));
    check({tag, "_out8"}, 32'(out8), 32'(exp_out8()));
    $display("t=%0t %s rst_n=%b s=%b out1=%h out8=%h cnt1=%0d cnt8=%0d",
             $time, tag, rst_n, s, out1, out8, cnt1, cnt8);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_s(input logic s_val, input string tag);
    @(negedge clk);
    s = s_val;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_async_reset();
    #1;
    check_all("rst_assert");
    tick("rst_hold");
    tick("rst_hold");
    @(negedge clk);
    s     = 1'b0;
    rst_n = 1'b1;
    #1;
    check_all("rst_release");
    repeat (3) tick("rst_sync");
  endtask

  logic [2:0] walk_vec [8];
  logic       walk_exp [8];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    s      = 1'b0;
    a0 = 1'b0; a1 = 1'b0; b0 = 8'h00; b1 = 8'h00;
    model_async_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick("post_reset");

    // Exhaustive {i0,i1,s} walk on the 1-bit instance
    walk_vec = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    walk_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      {a0, a1, s} = walk_vec[k];
      #1;
      check_all("walk_drive");
      tick("walk_edge");
      check("walk_const", 32'(out1), 32'(walk_exp[k]));
    end

    // 8-bit data path, select change without a clock edge
    b0 = 8'hA5;
    b1 = 8'h3C;
    drive_s(1'b0, "w8_s0");
    tick("w8_s0_edge");
    check("w8_s0_const", 32'(out8), 32'hA5);
    @(negedge clk);
    s = 1'b1;
    #1;
`ifdef MUX2_1_OUT_REG_EN
    check("w8_s1_noedge", 32'(out8), 32'hA5);
`else
    check("w8_s1_noedge", 32'(out8), 32'h3C);
`endif
    tick("w8_s1_edge");
    check("w8_s1_const", 32'(out8), 32'h3C);

    // Counting and saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_s(~s, "toggle");
      tick("toggle_edge");
    end
    check("cnt_after_toggle", 32'(cnt1), 32'd5);
    check("sat_after_toggle", 32'(cnt8), 32'd3);
    repeat (3) tick("hold");
    check("cnt_after_hold", 32'(cnt1), 32'd5);
    check("sat_after_hold", 32'(cnt8), 32'd3);

    // Async reset between edges; select activity while in reset is ignored
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    model_async_reset();
    #1;
    check("async_clr_cnt1", 32'(cnt1), 32'd0);
    check("async_clr_cnt8", 32'(cnt8), 32'd0);
    drive_s(1'b0, "in_rst");
    tick("in_rst_edge");
    drive_s(1'b1, "in_rst");
    tick("in_rst_edge");
    drive_s(1'b0, "in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick("release_sync");
    drive_s(1'b1, "one_toggle");
    tick("one_toggle_edge");
    check("cnt_one_toggle", 32'(cnt1), 32'd1);

`ifdef MUX2_1_OUT_REG_EN
    do_reset();
    @(negedge clk);
    {a0, a1, s} = 3'b011;
    #1;
    check("reg_before_edge", 32'(out1), 32'd0);
    tick("reg_edge");
    check("reg_after_edge", 32'(out1), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    model_async_reset();
    #1;
    check("reg_async_clr", 32'(out1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomised traffic with occasional mid-run resets
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      s  = ($urandom_range(0, 3) != 0) ? ~s : s;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_async_reset();
      end
      #1;
      check_all("rand_drive");
      tick("rand_edge");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
